// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle RV64M multiply/divide unit in the execute stage
// Ports: clk, resetn (async active-low); valid_i/op_i(funct3)/word_i/a_i/b_i describe the E-stage M op;
//   hold_i holds E externally, flush_i aborts; result_o is the registered result, ok_o=0 stalls F/D/E.
// Config: define MULDIV_FAST_MUL_EN for single-cycle multiplies (divides unchanged).
module muldiv_unit #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 7
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            valid_i,
  input  logic [2:0]      op_i,
  input  logic            word_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            hold_i,
  input  logic            flush_i,
  output logic [XLEN-1:0] result_o,
  output logic            ok_o
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [2:0] op_q;
  logic word_q, nq_q, nr_q;
  logic [XLEN-1:0] x_q;
  logic [2*XLEN-1:0] acc_q, mc_q;
  logic a_sgn, b_sgn, sa, sb, dz, ovf, accept, direct, last, ge;
  logic [XLEN-1:0] aw, bw, mag_a, mag_b, min_v, spec_res, direct_res, fin_res, x_n;
  logic [XLEN:0] r_sh, diff;
  logic [2*XLEN-1:0] acc_n, mc_n;

  // Applies the deferred sign correction and picks the half/word the op asks for.
  function automatic logic [XLEN-1:0] fin_sel(input logic [2:0] op, input logic word, nq, nr,
                                              input logic [2*XLEN-1:0] p, input logic [XLEN-1:0] q, r);
    logic [2*XLEN-1:0] ps;
    logic [XLEN-1:0] v;
    ps = nq ? -p : p;
    v = op[2] ? (op[1] ? (nr ? -r : r) : (nq ? -q : q))
              : (op[1:0] == 2'd0 ? ps[XLEN-1:0] : ps[2*XLEN-1:XLEN]);
    return word ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
  endfunction

  always_comb begin
    a_sgn = op_i[2] ? ~op_i[0] : (op_i[1:0] != 2'd3);
    b_sgn = op_i[2] ? ~op_i[0] : ~op_i[1];
    aw = word_i ? {{(XLEN-32){a_sgn & a_i[31]}}, a_i[31:0]} : a_i;
    bw = word_i ? {{(XLEN-32){b_sgn & b_i[31]}}, b_i[31:0]} : b_i;
    sa = a_sgn & aw[XLEN-1];
    sb = b_sgn & bw[XLEN-1];
    mag_a = sa ? -aw : aw;
    mag_b = sb ? -bw : bw;
    // Most negative value, already sign-extended for word ops.
    min_v = word_i ? {{(XLEN-31){1'b1}}, 31'b0} : {1'b1, {(XLEN-1){1'b0}}};
    dz = op_i[2] & (bw == '0);
    ovf = op_i[2] & ~op_i[0] & (aw == min_v) & (&bw);
    spec_res = dz ? (op_i[1] ? (word_i ? {{(XLEN-32){a_i[31]}}, a_i[31:0]} : a_i) : '1)
                  : (op_i[1] ? '0 : min_v);
`ifdef MULDIV_FAST_MUL_EN
    direct = ~op_i[2] | dz | ovf;
    direct_res = op_i[2] ? spec_res
               : fin_sel(op_i, word_i, sa ^ sb, sa, {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b}, '0, '0);
`else
    direct = dz | ovf;
    direct_res = spec_res;
`endif
    accept = state == IDLE & valid_i & ~flush_i;
    last = state == BUSY & cnt == '0;
    // Divide: restoring step, dividend bits enter from the top of x_q, quotient bits from the bottom.
    r_sh = {acc_q[XLEN-1:0], x_q[XLEN-1]};
    diff = r_sh - {1'b0, mc_q[XLEN-1:0]};
    ge = ~diff[XLEN];
    acc_n = op_q[2] ? {{XLEN{1'b0}}, ge ? diff[XLEN-1:0] : r_sh[XLEN-1:0]}
                    : acc_q + (x_q[0] ? mc_q : '0);
    mc_n = op_q[2] ? mc_q : mc_q << 1;
    x_n = op_q[2] ? {x_q[XLEN-2:0], ge} : x_q >> 1;
    fin_res = fin_sel(op_q, word_q, nq_q, nr_q, acc_n, x_n, acc_n[XLEN-1:0]);
    state_n = flush_i ? IDLE
            : state == IDLE ? (accept ? (direct ? DONE : BUSY) : IDLE)
            : state == BUSY ? (last ? DONE : BUSY)
            : (hold_i ? DONE : IDLE);
  end

  assign ok_o = (state == IDLE & ~valid_i) | state == DONE;

  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state <= IDLE;
    else state <= state_n;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      result_o <= '0;
      cnt <= '0;
      op_q <= '0;
      word_q <= 1'b0;
      nq_q <= 1'b0;
      nr_q <= 1'b0;
      x_q <= '0;
      acc_q <= '0;
      mc_q <= '0;
    end else if (accept) begin
      op_q <= op_i;
      word_q <= word_i;
      nq_q <= sa ^ sb;
      nr_q <= sa;
      cnt <= word_i ? CNT_W'(31) : CNT_W'(XLEN-1);
      acc_q <= '0;
      // Word dividends are left-aligned so the divide always consumes from the top bit.
      x_q <= ~op_i[2] ? mag_b : (word_i ? {mag_a[31:0], {(XLEN-32){1'b0}}} : mag_a);
      mc_q <= {{XLEN{1'b0}}, op_i[2] ? mag_b : mag_a};
      if (direct) result_o <= direct_res;
    end else if (state == BUSY & ~flush_i) begin
      acc_q <= acc_n;
      mc_q <= mc_n;
      x_q <= x_n;
      cnt <= cnt - 1'b1;
      if (last) result_o <= fin_res;
    end
  end
endmodule
